// File: rtl/pipe_arbiter.sv
// pipe_arbiter: packet-atomic round-robin arbiter merging Inputs valid/ready pipes into one.
// A channel keeps the grant from its first beat until its stop beat is accepted.
module pipe_arbiter #(
    parameter int Width = 8,
    parameter int Inputs = 4,
    localparam int IW = $clog2(Inputs)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [Inputs*Width-1:0] in_data,
    input  logic [Inputs-1:0]       in_valid,
    input  logic [Inputs-1:0]       in_start,
    input  logic [Inputs-1:0]       in_stop,
    output logic [Inputs-1:0]       in_ready,
    output logic [Width-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_start,
    output logic                    out_stop,
    input  logic                    out_ready,
    output logic                    grant_valid,
    output logic [IW-1:0]           grant_index
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state;
    logic [IW-1:0] last, grant, sel;
    logic done;
    // Scan offsets high-to-low so the nearest valid channel above last wins.
    always_comb begin
        sel = '0;
        for (int k = Inputs; k >= 1; k--)
            if (in_valid[(int'(last) + k) % Inputs]) sel = IW'((int'(last) + k) % Inputs);
    end
    always_comb begin
        in_ready = '0;
        if (grant_valid) in_ready[grant] = out_ready;
    end
    assign grant_valid = state == LOCKED;
    assign grant_index = grant;
    assign out_valid   = grant_valid & in_valid[grant];
    assign out_start   = grant_valid & in_start[grant];
    assign out_stop    = grant_valid & in_stop[grant];
    assign out_data    = grant_valid ? in_data[int'(grant)*Width +: Width] : '0;
    assign done        = out_valid & out_ready & in_stop[grant];
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            last  <= IW'(Inputs - 1);
            grant <= '0;
        end else if (!grant_valid) begin
            if (|in_valid) begin
                state <= LOCKED;
                grant <= sel;
            end
        end else if (done) begin
            state <= IDLE;
            last  <= grant;
            grant <= '0;
        end
    end
endmodule
